pcie_tx_arbiter: RTL

Packet-level round-robin arbiter that shares the single PCIe TX AXI-stream (the system-clock side of the DMA→PCIe response FIFO) between NSRC TLP sources. Typical sources are PIO completions, DMA read/write requests and MSI. A grant is held for a whole TLP, from the first beat through the accepted tlast beat, so TLPs are never interleaved. The block is fully synchronous to the system bus clock and sits between the TLP generators and the TX CDC FIFO write port.

---
 rtl/pcie_tx_arbiter_if.sv | 34 +++
 rtl/pcie_tx_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_arbiter_if.sv
// Bundle of per-source TLP streams plus the single arbitrated PCIe TX stream.
// The master modport is the arbiter; the slave modport is the surrounding logic.
interface pcie_tx_arbiter_if #(
  parameter int C_DATA_WIDTH = 64,
  parameter int NSRC         = 3
);
  localparam int KEEP_WIDTH = C_DATA_WIDTH / 8;

  logic [NSRC-1:0]              i_src_tvalid;
  logic [NSRC*C_DATA_WIDTH-1:0] i_src_tdata;
  logic [NSRC*KEEP_WIDTH-1:0]   i_src_tkeep;
  logic [NSRC-1:0]              i_src_tlast;
  logic [NSRC-1:0]              o_src_tready;
  logic                         i_tx_tready;
  logic [C_DATA_WIDTH-1:0]      o_tx_tdata;
  logic [KEEP_WIDTH-1:0]        o_tx_tkeep;
  logic                         o_tx_tlast;
  logic                         o_tx_tvalid;
  logic                         o_tx_src_dsc;
  logic                         o_busy;
  logic [NSRC-1:0]              o_grant;

  modport master (
    input  i_src_tvalid, i_src_tdata, i_src_tkeep, i_src_tlast, i_tx_tready,
    output o_src_tready, o_tx_tdata, o_tx_tkeep, o_tx_tlast, o_tx_tvalid,
           o_tx_src_dsc, o_busy, o_grant
  );

  modport slave (
    output i_src_tvalid, i_src_tdata, i_src_tkeep, i_src_tlast, i_tx_tready,
    input  o_src_tready, o_tx_tdata, o_tx_tkeep, o_tx_tlast, o_tx_tvalid,
           o_tx_src_dsc, o_busy, o_grant
  );
endinterface

// File: rtl/pcie_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the PCIe TX AXI-stream between NSRC TLP sources.
// Optional mid-packet starvation watchdog (abort + drain) enabled by macro PCIE_TXARB_WDOG_EN.
module pcie_tx_arbiter #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int NSRC         = 3,
  parameter int WDOG_LIMIT   = 255
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  pcie_tx_arbiter_if.master io_bus
);

  localparam int IW = $clog2(NSRC);

  if (NSRC < 2 || NSRC > 4 || WDOG_LIMIT < 1 || WDOG_LIMIT > 255 ||
      KEEP_WIDTH != C_DATA_WIDTH / 8) begin : g_bad_param
    $error("pcie_tx_arbiter: unsupported parameter combination");
  end

`ifdef PCIE_TXARB_WDOG_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ABORT, S_DRAIN} state_t;
`else
  typedef enum logic {S_IDLE, S_BUSY} state_t;
`endif

  state_t                  r_state, w_state_nxt;
  logic [NSRC-1:0]         r_grant, w_grant_nxt;
  logic [IW-1:0]           r_gidx, w_gidx_nxt;
  logic [IW-1:0]           r_rr, w_rr_nxt;
  logic [IW-1:0]           w_pick;
  logic                    w_any;
  logic                    w_sel_valid;
  logic                    w_sel_last;
  logic                    w_accept;
  logic [C_DATA_WIDTH-1:0] w_data_arr [NSRC];
  logic [KEEP_WIDTH-1:0]   w_keep_arr [NSRC];

  function automatic logic [IW-1:0] f_wrap_add(input logic [IW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NSRC) s = s - NSRC;
    return IW'(s);
  endfunction

  for (genvar k = 0; k < NSRC; k++) begin : g_unpack
    assign w_data_arr[k] = io_bus.i_src_tdata[k*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign w_keep_arr[k] = io_bus.i_src_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH];
  end

  assign w_sel_valid = io_bus.i_src_tvalid[r_gidx];
  assign w_sel_last  = io_bus.i_src_tlast[r_gidx];
  assign w_accept    = w_sel_valid & io_bus.i_tx_tready;

  // Scan downward so the lowest offset from r_rr is the one that sticks.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_rr;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (io_bus.i_src_tvalid[f_wrap_add(r_rr, i)]) begin
        w_any  = 1'b1;
        w_pick = f_wrap_add(r_rr, i);
      end
    end
  end

`ifdef PCIE_TXARB_WDOG_EN
  logic [7:0] r_wdog;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wdog <= '0;
    end else if (r_state != S_BUSY || w_accept) begin
      r_wdog <= '0;
    end else if (!w_sel_valid && io_bus.i_tx_tready && r_wdog != 8'hFF) begin
      r_wdog <= r_wdog + 8'd1;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_grant_nxt         = r_grant;
    w_gidx_nxt          = r_gidx;
    w_rr_nxt            = r_rr;
    io_bus.o_src_tready = '0;
    io_bus.o_tx_tdata   = '0;
    io_bus.o_tx_tkeep   = '0;
    io_bus.o_tx_tlast   = 1'b0;
    io_bus.o_tx_tvalid  = 1'b0;
    io_bus.o_tx_src_dsc = 1'b0;
    io_bus.o_busy       = 1'b0;
    io_bus.o_grant      = '0;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_BUSY;
          w_gidx_nxt  = w_pick;
          w_grant_nxt = NSRC'(1) << w_pick;
        end
      end

      S_BUSY: begin
        io_bus.o_tx_tdata   = w_data_arr[r_gidx];
        io_bus.o_tx_tkeep   = w_keep_arr[r_gidx];
        io_bus.o_tx_tlast   = w_sel_last;
        io_bus.o_tx_tvalid  = w_sel_valid;
        io_bus.o_src_tready = r_grant & {NSRC{io_bus.i_tx_tready}};
        io_bus.o_busy       = 1'b1;
        io_bus.o_grant      = r_grant;
        if (w_accept && w_sel_last) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_rr_nxt    = f_wrap_add(r_gidx, 1);
        end
`ifdef PCIE_TXARB_WDOG_EN
        else if (!w_accept && int'(r_wdog) >= WDOG_LIMIT) begin
          w_state_nxt = S_ABORT;
        end
`endif
      end

`ifdef PCIE_TXARB_WDOG_EN
      // Synthetic discontinue beat closes the TLP downstream before the source is flushed.
      S_ABORT: begin
        io_bus.o_tx_tvalid  = 1'b1;
        io_bus.o_tx_tlast   = 1'b1;
        io_bus.o_tx_src_dsc = 1'b1;
        io_bus.o_busy       = 1'b1;
        io_bus.o_grant      = r_grant;
        if (io_bus.i_tx_tready) w_state_nxt = S_DRAIN;
      end

      S_DRAIN: begin
        io_bus.o_src_tready = r_grant;
        io_bus.o_busy       = 1'b1;
        io_bus.o_grant      = r_grant;
        if (w_sel_valid && w_sel_last) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_rr_nxt    = f_wrap_add(r_gidx, 1);
        end
      end
`endif

      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

endmodule
